code_fetch: RTL and testbench

- Supplies the execution core's `opcode` and `code_data` inputs.
- Takes a program counter, reads the opcode byte from a byte-wide code memory, and for PUSH1..PUSH32 (0x60..0x7F) also reads the immediate bytes.
- Packs the immediate big-endian and right-aligned into a 256-bit word.
- Presents the result with a valid/ready handshake.
- Sits between the code memory and the execution core's pc_o/opcode/code_data interface.

---
 rtl/code_fetch.sv | 172 +++++++++++++++++
 tb/tb_code_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_fetch.sv
// Opcode/immediate fetch unit: reads an opcode byte and any PUSH1..PUSH32 immediate from byte-wide code memory.
// Optional build macro CODE_FETCH_STATS_EN adds a saturating rd_count output of accepted memory returns.
module code_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] code_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] code_data,
  output logic              valid,
  input  logic              ready,
  output logic              busy
`ifdef CODE_FETCH_STATS_EN
  ,
  output logic [31:0]       rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, OP_WAIT, IMM_WAIT, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W-1:0]   len_reg, len_next;
  logic [7:0]          op_reg, op_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [4:0]          last_reg, last_next;   // index of the final immediate byte (n-1)
  logic [4:0]          k_reg, k_next;
  logic                pend_reg, pend_next;   // one read outstanding
  logic                rd_reg, rd_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;

  logic                rd_accept;
  logic                issue;
  logic [4:0]          issue_k;
  logic [ADDR_W:0]     issue_addr;

  assign rd_accept = mem_rvalid && pend_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      len_reg   <= '0;
      op_reg    <= '0;
      data_reg  <= '0;
      last_reg  <= '0;
      k_reg     <= '0;
      pend_reg  <= 1'b0;
      rd_reg    <= 1'b0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      len_reg   <= len_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      k_reg     <= k_next;
      pend_reg  <= pend_next;
      rd_reg    <= rd_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    k_next     = k_reg;
    pend_next  = pend_reg;
    rd_next    = 1'b0;
    addr_next  = addr_reg;
    issue      = 1'b0;
    issue_k    = '0;
    issue_addr = '0;

    case (state_reg)
      IDLE: begin
        if (fetch_req) begin
          pc_next   = pc_i;
          len_next  = code_len;
          data_next = '0;
          op_next   = 8'h00;
          if (pc_i < code_len) begin
            rd_next    = 1'b1;
            addr_next  = pc_i;
            pend_next  = 1'b1;
            state_next = OP_WAIT;
          end else begin
            state_next = HOLD;
          end
        end
      end
      OP_WAIT: begin
        if (rd_accept) begin
          pend_next = 1'b0;
          op_next   = mem_rdata;
          if (mem_rdata[7:5] == 3'b011) begin
            last_next  = mem_rdata[4:0];
            k_next     = '0;
            issue      = 1'b1;
            issue_k    = '0;
            state_next = IMM_WAIT;
          end else begin
            state_next = HOLD;
          end
        end
      end
      IMM_WAIT: begin
        // Without an outstanding read this cycle is a zero-fill step past the end of code.
        if (!pend_reg || rd_accept) begin
          data_next = {data_reg[DATA_W-9:0], (pend_reg ? mem_rdata : 8'h00)};
          pend_next = 1'b0;
          if (k_reg == last_reg) begin
            state_next = HOLD;
          end else begin
            k_next  = k_reg + 5'd1;
            issue   = 1'b1;
            issue_k = k_reg + 5'd1;
          end
        end
      end
      HOLD: begin
        if (ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Immediate address computed one bit wider so a wrap past the top of memory stays out of range.
    if (issue) begin
      issue_addr = {1'b0, pc_reg} + (ADDR_W+1)'(issue_k) + (ADDR_W+1)'(1);
      if (issue_addr < {1'b0, len_reg}) begin
        rd_next   = 1'b1;
        addr_next = issue_addr[ADDR_W-1:0];
        pend_next = 1'b1;
      end
    end
  end

  assign mem_rd    = rd_reg;
  assign mem_addr  = addr_reg;
  assign opcode    = op_reg;
  assign code_data = data_reg;
  assign valid     = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);

`ifdef CODE_FETCH_STATS_EN
  logic [31:0] rd_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_reg <= '0;
    end else if (rd_accept && (rd_count_reg != 32'hFFFF_FFFF)) begin
      rd_count_reg <= rd_count_reg + 32'd1;
    end
  end

  assign rd_count = rd_count_reg;
`endif

endmodule

// File: tb/tb_code_fetch.sv
// Scoreboard bench for code_fetch: stimulus queues expected results, a monitor checks each new valid.
// Memory model returns reads after a programmable latency.
module tb_code_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req;
  logic [15:0]  pc_i;
  logic [15:0]  code_len;
  logic         mem_rd;
  logic [15:0]  mem_addr;
  logic [7:0]   mem_rdata;
  logic         mem_rvalid;
  logic [7:0]   opcode;
  logic [255:0] code_data;
  logic         valid;
  logic         ready;
  logic         busy;
`ifdef CODE_FETCH_STATS_EN
  logic [31:0]  rd_count;
`endif

  code_fetch #(.ADDR_W(16), .DATA_W(256)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_i(pc_i), .code_len(code_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .opcode(opcode), .code_data(code_data), .valid(valid), .ready(ready), .busy(busy)
`ifdef CODE_FETCH_STATS_EN
    , .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   op;
    logic [255:0] data;
    int           nreads;
    int           lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [0:65535];
  int         mem_lat = 1;
  int         reads = 0;
  int         reads_base = 0;
  int         cyc = 0;
  int         req_cyc = 0;
  int         done_cnt = 0;
  int         total = 0;
  int         passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Memory: samples mem_rd mid-cycle, returns data mem_lat cycles later for one cycle.
  initial begin : memory_model
    int cd;
    logic [15:0] raddr;
    cd = 0;
    raddr = '0;
    mem_rvalid = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        raddr = mem_addr;
        cd = mem_lat;
        reads++;
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem[raddr];
        end
      end
    end
  end

  // Monitor: each rising valid pops one expected result.
  initial begin : monitor
    logic valid_prev;
    exp_t e;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && !valid_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: got opcode %0h with no pending request", opcode);
        end else begin
          e = exp_q.pop_front();
          chk("opcode", 256'(opcode), 256'(e.op));
          chk("code_data", code_data, e.data);
          chk("reads", 256'(reads - reads_base), 256'(e.nreads));
          chk("latency", 256'(cyc - req_cyc), 256'(e.lat));
          $display("txn pc=%0h len=%0h op=%0h data=%0h reads=%0d lat=%0d",
                   pc_i, code_len, opcode, code_data, reads - reads_base, cyc - req_cyc);
        end
        done_cnt++;
      end
      valid_prev = (valid === 1'b1);
    end
  end

  task automatic start_req(input logic [15:0] pc, input logic [15:0] len);
    @(negedge clk);
    reads_base = reads;
    req_cyc = cyc;
    pc_i = pc;
    code_len = len;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      $display("FAIL timeout: no valid after %0d cycles", n);
    end
  endtask

  task automatic run(input logic [15:0] pc, input logic [15:0] len, input logic [7:0] op,
                     input logic [255:0] data, input int nreads, input int lat);
    exp_t e;
    int d0;
    e.op = op;
    e.data = data;
    e.nreads = nreads;
    e.lat = lat;
    exp_q.push_back(e);
    d0 = done_cnt;
    start_req(pc, len);
    wait_done(d0);
    @(negedge clk);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  initial begin : stimulus
    logic [255:0] d32;
    int viol;
    int base;
    int d0;
    int n;
`ifdef CODE_FETCH_STATS_EN
    logic [31:0] cnt0;
`endif
    clear_mem();
    rst = 1'b1;
    fetch_req = 1'b0;
    pc_i = '0;
    code_len = '0;
    ready = 1'b1;
    #3;
    chk("rst_mem_rd", 256'(mem_rd), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_opcode", 256'(opcode), 256'(0));
    chk("rst_code_data", code_data, 256'(0));
    chk("rst_valid", 256'(valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Non-PUSH opcode, 1-cycle memory: valid 3 cycles after request.
    mem[0] = 8'h01;
    run(16'd0, 16'd1, 8'h01, 256'h0, 1, 3);

    // PUSH2 fully in range.
    clear_mem();
    mem[0] = 8'h61; mem[1] = 8'hAB; mem[2] = 8'hCD;
`ifdef CODE_FETCH_STATS_EN
    cnt0 = rd_count;
`endif
    run(16'd0, 16'd3, 8'h61, 256'hABCD, 3, 7);
`ifdef CODE_FETCH_STATS_EN
    chk("rd_count_push2", 256'(rd_count - cnt0), 256'(3));
`endif

    // PUSH32 filling the whole word.
    clear_mem();
    mem[0] = 8'h7F;
    d32 = '0;
    for (int i = 1; i <= 32; i++) begin
      mem[i] = 8'(i);
      d32 = {d32[247:0], 8'(i)};
    end
    run(16'd0, 16'd33, 8'h7F, d32, 33, 67);

    // Truncated PUSH2: last byte zero-filled without a read.
    clear_mem();
    mem[0] = 8'h61; mem[1] = 8'hAA; mem[2] = 8'h55;
    run(16'd0, 16'd2, 8'h61, 256'hAA00, 2, 6);

    // pc at end of code, and at the top of the address space: STOP with no read.
    mem[5] = 8'h42;
    run(16'd5, 16'd5, 8'h00, 256'h0, 0, 1);
    mem[16'hFFFF] = 8'h60;
    run(16'hFFFF, 16'hFFFF, 8'h00, 256'h0, 0, 1);

    // Immediate bytes at 0xFFFF and past the wrap are both out of range.
    clear_mem();
    mem[16'hFFFE] = 8'h61; mem[16'hFFFF] = 8'h77; mem[0] = 8'h88;
    run(16'hFFFE, 16'hFFFF, 8'h61, 256'h0, 1, 5);

    // PUSH1 with a 2-cycle memory.
    clear_mem();
    mem_lat = 2;
    mem[0] = 8'h60; mem[1] = 8'h5A;
    run(16'd0, 16'd2, 8'h60, 256'h5A, 2, 7);
    mem_lat = 1;

    // Backpressure: hold results for 10 cycles while fetch_req is asserted.
    clear_mem();
    mem[0] = 8'h61; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h02;
    ready = 1'b0;
    begin
      exp_t e;
      e.op = 8'h61; e.data = 256'h1234; e.nreads = 3; e.lat = 7;
      exp_q.push_back(e);
    end
    d0 = done_cnt;
    start_req(16'd0, 16'd4);
    wait_done(d0);
    base = reads;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      pc_i = 16'd3;
      if (valid !== 1'b1 || opcode !== 8'h61 || code_data !== 256'h1234) viol++;
    end
    chk("hold_stable", 256'(viol), 256'(0));
    chk("hold_no_read", 256'(reads - base), 256'(0));
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("accept_busy", 256'(busy), 256'(0));
    chk("accept_valid", 256'(valid), 256'(0));
    @(negedge clk);
    chk("accept_ignores_req", 256'({busy, mem_rd}), 256'(0));
    $display("txn backpressure hold viol=%0d", viol);

    // Reset in IMM_WAIT with a read still outstanding; its late return must be ignored.
    clear_mem();
    mem_lat = 3;
    mem[0] = 8'h61; mem[1] = 8'h11; mem[2] = 8'h22;
    start_req(16'd0, 16'd3);
    n = 0;
    while ((reads - reads_base) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("imm_read_issued", 256'(reads - reads_base), 256'(2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {opcode, code_data[7:0], mem_rd, valid, busy}, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || opcode !== 8'h00 || code_data !== 256'h0)
        viol++;
    end
    chk("late_rvalid_ignored", 256'(viol), 256'(0));
`ifdef CODE_FETCH_STATS_EN
    chk("rd_count_after_rst", 256'(rd_count), 256'(0));
`endif
    $display("txn reset mid-immediate viol=%0d", viol);

    // Normal operation resumes after reset.
    mem_lat = 1;
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'hC3;
    run(16'd0, 16'd2, 8'h60, 256'hC3, 2, 5);

    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
